// File: rtl/raven_pe_pkg.sv
// rtl/raven_pe_pkg.sv - shared types and arithmetic helpers for the RAVEN saturating PE
// Contents:
//   pe_mode_e  - operating mode of the PE (gemm / div / exp / log)
//   sat_res_t  - saturated value plus overflow indication
//   sat_acc    - clamp (or wrap) a wide sum to an acc_bw-bit signed range
//   trunc_mac  - clamp a neighbour accumulator and drop its fraction bits
package raven_pe_pkg;

  typedef enum logic [1:0] {
    PE_GEMM = 2'b00,
    PE_DIV  = 2'b01,
    PE_EXP  = 2'b10,
    PE_LOG  = 2'b11
  } pe_mode_e;

  // Helpers work on a 64-bit signed carrier so they serve any legal width.
  localparam int WIDE_BW = 64;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_res_t;

  // Range check against acc_bw-bit two's complement. With sat_en the value is
  // pinned to the violated bound; otherwise it passes through and the caller's
  // truncation to acc_bw bits produces the wrapped result.
  function automatic sat_res_t sat_acc(input logic signed [63:0] sum,
                                       input int                 acc_bw,
                                       input bit                 sat_en);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    hi    = (64'sd1 <<< (acc_bw - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (acc_bw - 1));
    r.val = sum;
    r.ovf = 1'b0;
    if (sum > hi) begin
      r.ovf = 1'b1;
      if (sat_en) r.val = hi;
    end else if (sum < lo) begin
      r.ovf = 1'b1;
      if (sat_en) r.val = lo;
    end
    return r;
  endfunction

  // Clamp so the integer part fits mul_bw bits, then arithmetic shift right,
  // which floors toward minus infinity.
  function automatic logic signed [63:0] trunc_mac(input logic signed [63:0] mac,
                                                   input int                 mul_bw,
                                                   input int                 fra_bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] c;
    hi = ((64'sd1 <<< (mul_bw - 1)) - 64'sd1) <<< fra_bw;
    lo = -((64'sd1 <<< (mul_bw - 1)) <<< fra_bw);
    c  = mac;
    if (mac > hi) c = hi;
    else if (mac < lo) c = lo;
    return c >>> fra_bw;
  endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// rtl/pe_mul_pipe.sv - signed multiplier with optional product/addend/valid register
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   en           - global stall, 0 holds the pipeline register
//   op_a, op_b   - signed multiplicands (MUL_BW)
//   addend       - signed addend travelling alongside the product (ACC_BW)
//   beat_vld     - valid bit of the beat entering the multiplier
//   prod         - product presented to the accumulator (2*MUL_BW)
//   sum_add      - addend aligned with prod
//   sum_vld      - valid bit aligned with prod
//   busy         - a valid beat sits in the product register
module pe_mul_pipe
  import raven_pe_pkg::*;
#(
  parameter int MUL_BW   = 16,
  parameter int ACC_BW   = 32,
  parameter int PIPE_MUL = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [MUL_BW-1:0]   op_a,
  input  logic signed [MUL_BW-1:0]   op_b,
  input  logic signed [ACC_BW-1:0]   addend,
  input  logic                       beat_vld,
  output logic signed [2*MUL_BW-1:0] prod,
  output logic signed [ACC_BW-1:0]   sum_add,
  output logic                       sum_vld,
  output logic                       busy
);

  localparam int PW = 2 * MUL_BW;
  localparam bit PIPED = (PIPE_MUL != 0);

  logic signed [PW-1:0]     prod_c;
  logic signed [PW-1:0]     prod_q;
  logic signed [ACC_BW-1:0] add_q;
  logic                     vld_p;

  assign prod_c = PW'(op_a) * PW'(op_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      add_q  <= '0;
      vld_p  <= 1'b0;
    end else if (en) begin
      prod_q <= prod_c;
      add_q  <= addend;
      vld_p  <= beat_vld;
    end
  end

  // Unpipelined build bypasses the register and never reports it busy.
  assign prod    = PIPED ? prod_q : prod_c;
  assign sum_add = PIPED ? add_q  : addend;
  assign sum_vld = PIPED ? vld_p  : beat_vld;
  assign busy    = PIPED ? vld_p  : 1'b0;

endmodule

// File: rtl/pe_mp_sat.sv
// rtl/pe_mp_sat.sv - RAVEN systolic PE: GEMM / unary MAC with saturating accumulate
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   en                    - global stall, 0 freezes every register
//   cfg_vld_i/cfg_mode_i  - mode-change request and requested mode
//   cfg_rdy_o             - request accepted this cycle (pipeline drained)
//   vld_i                 - operand beat valid
//   mac_i, o_i            - neighbour accumulator, upstream partial sum
//   var_i, x_i, wc_i      - variable, activation, weight/coefficient
//   vld_o, var_o, x_o, wc_o - registered operands forwarded to neighbours
//   mac_o, o_o            - result register
//   res_vld_o             - result valid
//   mode_o                - current mode
//   ovf_o                 - sticky overflow flag, cleared by a mode change
module pe_mp_sat
  import raven_pe_pkg::*;
#(
  parameter int INT_BW   = 5,
  parameter int FRA_BW   = 10,
  parameter int MUL_BW   = 16,
  parameter int ACC_BW   = 32,
  parameter int PIPE_MUL = 0,
  parameter int SAT_EN   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     cfg_vld_i,
  input  logic [1:0]               cfg_mode_i,
  output logic                     cfg_rdy_o,
  input  logic                     vld_i,
  input  logic signed [ACC_BW-1:0] mac_i,
  input  logic signed [MUL_BW-1:0] var_i,
  input  logic signed [MUL_BW-1:0] x_i,
  input  logic signed [MUL_BW-1:0] wc_i,
  input  logic signed [ACC_BW-1:0] o_i,
  output logic                     vld_o,
  output logic [MUL_BW-1:0]        var_o,
  output logic [MUL_BW-1:0]        x_o,
  output logic [MUL_BW-1:0]        wc_o,
  output logic [ACC_BW-1:0]        mac_o,
  output logic [ACC_BW-1:0]        o_o,
  output logic                     res_vld_o,
  output logic [1:0]               mode_o,
  output logic                     ovf_o
);

  // Stage A operand registers
  logic signed [MUL_BW-1:0] wreg;
  logic signed [MUL_BW-1:0] ireg;
  logic signed [MUL_BW-1:0] vreg;
  logic                     vld_a;

  // Result / control state
  logic [ACC_BW-1:0]        oreg;
  logic                     res_vld;
  pe_mode_e                 mode_q;
  logic                     ovf_q;

  // Datapath
  logic signed [MUL_BW-1:0]   mac_t;
  logic signed [MUL_BW-1:0]   mul_a;
  logic signed [MUL_BW-1:0]   mul_b;
  logic signed [ACC_BW-1:0]   add;
  logic signed [2*MUL_BW-1:0] prod;
  logic signed [ACC_BW-1:0]   sum_add;
  logic                       sum_vld;
  logic                       mul_busy;
  logic signed [63:0]         sum_wide;
  sat_res_t                   sat_r;
  logic [ACC_BW-1:0]          sat_val;
  logic                       hs;

  assign mac_t = MUL_BW'(trunc_mac(64'(mac_i), MUL_BW, FRA_BW));

  always_comb begin
    mul_a = wreg;
    mul_b = ireg;
    add   = o_i;
    if (mode_q != PE_GEMM) begin
      mul_a = mac_t;
      mul_b = vreg;
      // Horner constant term: coefficient scaled to the accumulator's 2*FRA_BW fraction
      add   = ACC_BW'(wreg) <<< FRA_BW;
    end
  end

  pe_mul_pipe #(
    .MUL_BW  (MUL_BW),
    .ACC_BW  (ACC_BW),
    .PIPE_MUL(PIPE_MUL)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .op_a    (mul_a),
    .op_b    (mul_b),
    .addend  (add),
    .beat_vld(vld_a),
    .prod    (prod),
    .sum_add (sum_add),
    .sum_vld (sum_vld),
    .busy    (mul_busy)
  );

  // Sum formed wide so the range check sees the true value before wrap/clamp.
  assign sum_wide = 64'(prod) + 64'(sum_add);
  assign sat_r    = sat_acc(sum_wide, ACC_BW, SAT_EN != 0);
  assign sat_val  = ACC_BW'(sat_r.val);

  // Mode may only change with nothing in flight anywhere in the PE.
  assign cfg_rdy_o = en & ~vld_a & ~mul_busy & ~res_vld;
  assign hs        = cfg_vld_i & cfg_rdy_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreg    <= '0;
      ireg    <= '0;
      vreg    <= '0;
      vld_a   <= 1'b0;
      oreg    <= '0;
      res_vld <= 1'b0;
      mode_q  <= PE_GEMM;
      ovf_q   <= 1'b0;
    end else if (en) begin
      wreg    <= wc_i;
      ireg    <= x_i;
      vreg    <= var_i;
      vld_a   <= vld_i;
      oreg    <= sat_val;
      res_vld <= sum_vld;
      // A handshake implies an empty pipeline, so clear never races a real set.
      if (hs) begin
        mode_q <= pe_mode_e'(cfg_mode_i);
        ovf_q  <= 1'b0;
      end else if (sum_vld && sat_r.ovf) begin
        ovf_q  <= 1'b1;
      end
    end
  end

  assign wc_o      = wreg;
  assign x_o       = ireg;
  assign var_o     = vreg;
  assign vld_o     = vld_a;
  assign mac_o     = oreg;
  assign o_o       = oreg;
  assign res_vld_o = res_vld;
  assign mode_o    = mode_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_pe_mp_sat.sv
// tb/tb_pe_mp_sat.sv - directed self-checking bench for pe_mp_sat
// Instances: [0] PIPE_MUL=0 SAT_EN=1, [1] PIPE_MUL=1 SAT_EN=1, [2] PIPE_MUL=0 SAT_EN=0
module tb_pe_mp_sat;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        cfg_vld;
  logic [1:0]  cfg_mode;
  logic        vld;
  logic [31:0] mac;
  logic [15:0] var_v;
  logic [15:0] x;
  logic [15:0] wc;
  logic [31:0] o;

  logic        cfg_rdy_o [3];
  logic        vld_o     [3];
  logic [15:0] var_o     [3];
  logic [15:0] x_o       [3];
  logic [15:0] wc_o      [3];
  logic [31:0] mac_o     [3];
  logic [31:0] o_o       [3];
  logic        res_vld_o [3];
  logic [1:0]  mode_o    [3];
  logic        ovf_o     [3];

  int n_checks;
  int n_fail;

  localparam int PIPE_CFG [3] = '{0, 1, 0};
  localparam int SAT_CFG  [3] = '{1, 1, 0};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pe_mp_sat #(
      .INT_BW(5), .FRA_BW(10), .MUL_BW(16), .ACC_BW(32),
      .PIPE_MUL(PIPE_CFG[g]), .SAT_EN(SAT_CFG[g])
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_vld_i (cfg_vld),
      .cfg_mode_i(cfg_mode),
      .cfg_rdy_o (cfg_rdy_o[g]),
      .vld_i     (vld),
      .mac_i     (mac),
      .var_i     (var_v),
      .x_i       (x),
      .wc_i      (wc),
      .o_i       (o),
      .vld_o     (vld_o[g]),
      .var_o     (var_o[g]),
      .x_o       (x_o[g]),
      .wc_o      (wc_o[g]),
      .mac_o     (mac_o[g]),
      .o_o       (o_o[g]),
      .res_vld_o (res_vld_o[g]),
      .mode_o    (mode_o[g]),
      .ovf_o     (ovf_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; en = 1'b1; cfg_vld = 1'b0; cfg_mode = 2'b00;
    vld = 1'b0; mac = '0; var_v = '0; x = '0; wc = '0; o = '0;
    tick(); tick();

    // reset state
    for (int k = 0; k < 3; k++) begin
      chk("rst_res_vld", k, 64'(res_vld_o[k]), 64'h0);
      chk("rst_o",       k, 64'(o_o[k]),       64'h0);
      chk("rst_mode",    k, 64'(mode_o[k]),    64'h0);
      chk("rst_ovf",     k, 64'(ovf_o[k]),     64'h0);
      chk("rst_vld_o",   k, 64'(vld_o[k]),     64'h0);
    end
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) chk("rel_cfg_rdy", k, 64'(cfg_rdy_o[k]), 64'h1);

    // GEMM 1.0 * 2.0 + 0x100
    wc = 16'h0400; x = 16'h0800; var_v = 16'h0123; vld = 1'b1;
    tick();
    chk("fwd_vld_o", 0, 64'(vld_o[0]), 64'h1);
    chk("fwd_wc_o",  0, 64'(wc_o[0]),  64'h0400);
    chk("fwd_x_o",   0, 64'(x_o[0]),   64'h0800);
    chk("fwd_var_o", 0, 64'(var_o[0]), 64'h0123);
    wc = '0; x = '0; var_v = '0; vld = 1'b0; o = 32'h0000_0100;
    tick();
    chk("gemm_res_vld", 0, 64'(res_vld_o[0]), 64'h1);
    chk("gemm_o",       0, 64'(o_o[0]),       64'h0020_0100);
    chk("gemm_mac",     0, 64'(mac_o[0]),     64'h0020_0100);
    chk("gemm_o",       2, 64'(o_o[2]),       64'h0020_0100);
    chk("gemm_res_vld", 1, 64'(res_vld_o[1]), 64'h0);
    o = '0;
    tick();
    chk("gemm_res_vld", 1, 64'(res_vld_o[1]), 64'h1);
    chk("gemm_o",       1, 64'(o_o[1]),       64'h0020_0100);
    chk("gemm_res_end", 0, 64'(res_vld_o[0]), 64'h0);

    // saturation / wrap
    wc = 16'h7FFF; x = 16'h7FFF; vld = 1'b1;
    tick();
    wc = '0; x = '0; vld = 1'b0; o = 32'h7FFF_FFFF;
    tick();
    chk("sat_o",   0, 64'(o_o[0]),   64'h7FFF_FFFF);
    chk("sat_ovf", 0, 64'(ovf_o[0]), 64'h1);
    chk("wrap_o",  2, 64'(o_o[2]),   64'hBFFF_0000);
    chk("wrap_ovf",2, 64'(ovf_o[2]), 64'h1);
    chk("sat_ovf_early", 1, 64'(ovf_o[1]), 64'h0);
    o = '0;
    tick();
    chk("sat_o",   1, 64'(o_o[1]),   64'h7FFF_FFFF);
    chk("sat_ovf", 1, 64'(ovf_o[1]), 64'h1);
    wc = 16'h0400; x = 16'h0400; vld = 1'b1;
    tick();
    wc = '0; x = '0; vld = 1'b0;
    tick();
    chk("clean_o",     0, 64'(o_o[0]),   64'h0010_0000);
    chk("ovf_sticky",  0, 64'(ovf_o[0]), 64'h1);
    tick();
    chk("clean_o",     1, 64'(o_o[1]),   64'h0010_0000);
    chk("ovf_sticky",  1, 64'(ovf_o[1]), 64'h1);

    // handshake to div: [0] idle, [1] still holding a result
    cfg_vld = 1'b1; cfg_mode = 2'b01;
    #1;
    chk("hs_rdy", 0, 64'(cfg_rdy_o[0]), 64'h1);
    chk("hs_rdy", 1, 64'(cfg_rdy_o[1]), 64'h0);
    tick();
    chk("hs_mode",     0, 64'(mode_o[0]),    64'h1);
    chk("hs_ovf_clr",  0, 64'(ovf_o[0]),     64'h0);
    chk("hs_ovf_clr",  2, 64'(ovf_o[2]),     64'h0);
    chk("hs_mode_wait",1, 64'(mode_o[1]),    64'h0);
    chk("hs_ovf_keep", 1, 64'(ovf_o[1]),     64'h1);
    chk("hs_rdy_late", 1, 64'(cfg_rdy_o[1]), 64'h1);
    tick();
    chk("hs_mode",     1, 64'(mode_o[1]),    64'h1);
    chk("hs_ovf_clr",  1, 64'(ovf_o[1]),     64'h0);
    cfg_vld = 1'b0;

    // unary clamp: positive clamp, negative clamp, floor of -1 LSB
    mac = 32'h7FFF_FFFF; var_v = 16'h0400; wc = 16'h0001; vld = 1'b1;
    tick();
    wc = '0; var_v = '0; vld = 1'b0;
    tick();
    chk("div_pos_o", 0, 64'(o_o[0]), 64'h0200_0000);
    chk("div_ovf",   0, 64'(ovf_o[0]), 64'h0);
    tick();
    chk("div_pos_o", 1, 64'(o_o[1]), 64'h0200_0000);
    mac = 32'h8000_0000; var_v = 16'h0400; vld = 1'b1;
    tick();
    var_v = '0; vld = 1'b0;
    tick();
    chk("div_neg_o", 0, 64'(o_o[0]), 64'hFE00_0000);
    tick();
    chk("div_neg_o", 1, 64'(o_o[1]), 64'hFE00_0000);
    mac = 32'hFFFF_FFFF; var_v = 16'h0400; vld = 1'b1;
    tick();
    var_v = '0; vld = 1'b0;
    tick();
    chk("div_floor_o", 0, 64'(o_o[0]), 64'hFFFF_FC00);
    tick();
    chk("div_floor_o", 1, 64'(o_o[1]), 64'hFFFF_FC00);
    mac = '0;
    tick();

    // handshake to exp with two beats in flight
    vld = 1'b1;
    tick();
    cfg_vld = 1'b1; cfg_mode = 2'b10;
    #1;
    chk("busy_rdy", 0, 64'(cfg_rdy_o[0]), 64'h0);
    tick();
    vld = 1'b0;
    tick();
    chk("busy_rdy",  0, 64'(cfg_rdy_o[0]), 64'h0);
    chk("busy_mode", 0, 64'(mode_o[0]),    64'h1);
    tick();
    chk("drain_res_vld", 0, 64'(res_vld_o[0]), 64'h0);
    chk("drain_rdy",     0, 64'(cfg_rdy_o[0]), 64'h1);
    chk("drain_mode",    0, 64'(mode_o[0]),    64'h1);
    chk("busy_rdy",      1, 64'(cfg_rdy_o[1]), 64'h0);
    tick();
    chk("exp_mode",  0, 64'(mode_o[0]),    64'h2);
    chk("exp_ovf",   0, 64'(ovf_o[0]),     64'h0);
    chk("drain_rdy", 1, 64'(cfg_rdy_o[1]), 64'h1);
    chk("drain_mode",1, 64'(mode_o[1]),    64'h1);
    tick();
    chk("exp_mode",  1, 64'(mode_o[1]),    64'h2);
    cfg_vld = 1'b0;

    // back to gemm
    cfg_vld = 1'b1; cfg_mode = 2'b00;
    tick();
    cfg_vld = 1'b0;
    chk("gemm_mode", 0, 64'(mode_o[0]), 64'h0);
    chk("gemm_mode", 1, 64'(mode_o[1]), 64'h0);

    // stall for 3 cycles with the beat held in stage A
    wc = 16'h0400; x = 16'h0C00; vld = 1'b1;
    tick();
    wc = '0; x = '0; vld = 1'b0; en = 1'b0; o = 32'h0000_0055;
    #1;
    chk("stall_rdy", 0, 64'(cfg_rdy_o[0]), 64'h0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_vld_o",   s, 64'(vld_o[0]),     64'h1);
      chk("stall_wc_o",    s, 64'(wc_o[0]),      64'h0400);
      chk("stall_res_vld", s, 64'(res_vld_o[0]), 64'h0);
      chk("stall_rdy",     s, 64'(cfg_rdy_o[1]), 64'h0);
    end
    en = 1'b1;
    tick();
    chk("resume_res_vld", 0, 64'(res_vld_o[0]), 64'h1);
    chk("resume_o",       0, 64'(o_o[0]),       64'h0030_0055);
    chk("resume_res_vld", 1, 64'(res_vld_o[1]), 64'h0);
    en = 1'b0; o = '0;
    tick();
    chk("hold_res_vld", 0, 64'(res_vld_o[0]), 64'h1);
    chk("hold_o",       0, 64'(o_o[0]),       64'h0030_0055);
    chk("hold_res_vld", 1, 64'(res_vld_o[1]), 64'h0);
    en = 1'b1;
    tick();
    chk("resume_res_vld", 1, 64'(res_vld_o[1]), 64'h1);
    chk("resume_o",       1, 64'(o_o[1]),       64'h0030_0055);

    // reset with beats in flight and the flag set
    wc = 16'h7FFF; x = 16'h7FFF; vld = 1'b1;
    tick();
    o = 32'h7FFF_FFFF;
    tick();
    chk("pre_rst_ovf", 0, 64'(ovf_o[0]), 64'h1);
    vld = 1'b0; o = '0; wc = '0; x = '0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_vld_o",   k, 64'(vld_o[k]),     64'h0);
      chk("arst_res_vld", k, 64'(res_vld_o[k]), 64'h0);
      chk("arst_o",       k, 64'(o_o[k]),       64'h0);
      chk("arst_ovf",     k, 64'(ovf_o[k]),     64'h0);
      chk("arst_mode",    k, 64'(mode_o[k]),    64'h0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_res_vld", k, 64'(res_vld_o[k]), 64'h0);
      chk("post_rst_rdy",     k, 64'(cfg_rdy_o[k]), 64'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
